e1_rx_liu: RTL and testbench

Receive-side interface to the external E1 line interface unit (LIU), the counterpart of the TX LIU block. It samples the LIU's recovered bit clock and data pads in the fabric `clk` domain and filters the clock for glitches. On each active clock edge it produces a single-cycle `out_valid` strobe with the sampled bit. It also flags loss of the LIU clock and recovery from it. Output feeds the E1 RX framer/deframer chain.

---
 rtl/e1_rx_liu.sv | 228 ++++++++++++++++++++++
 tb/tb_e1_rx_liu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e1_rx_liu.sv
`default_nettype none
// ============================================================================
// Module   : e1_rx_liu
// Purpose  : Receive-side interface to the external E1 line interface unit.
//            Registers the LIU recovered clock and data pads in the fabric
//            clock domain, synchronises them, de-glitches the recovered
//            clock and emits one strobe per accepted active clock edge
//            carrying the bit sampled at that edge. A loss-of-signal monitor
//            tracks the presence of the LIU clock and reports transitions.
// Ports    : clk            fabric clock (~15 clk per E1 bit)
//            rst_n          asynchronous active-low reset
//            pad_rx_data    LIU receive data pad
//            pad_rx_clk     LIU recovered clock pad
//            out_data       received bit, valid when out_valid=1
//            out_valid      one-cycle strobe per accepted bit
//            status_los     1 = loss of signal (no LIU clock)
//            status_los_chg one-cycle pulse on any status_los transition
// Revision : 1.0  initial release
// ============================================================================
module e1_rx_liu #(
   parameter int RX_EDGE     = 0,   // 0 = falling edge active, 1 = rising
   parameter int FILT_LEN    = 2,   // cycles a new level must persist (1..7)
   parameter int LOS_TIMEOUT = 63,  // idle cycles before LOS (1..63)
   parameter int LOS_RECOVER = 4    // in-time edges needed to leave LOS (1..15)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pad_rx_data,
   input  logic pad_rx_clk,
   output logic out_data,
   output logic out_valid,
   output logic status_los,
   output logic status_los_chg
);

   localparam logic [2:0] c_FILT_LAST = 3'(FILT_LEN - 1);
   localparam logic [5:0] c_TMO_MAX   = 6'(LOS_TIMEOUT);
   localparam logic [5:0] c_TMO_LAST  = 6'(LOS_TIMEOUT - 1);
   localparam logic [3:0] c_REC_LAST  = 4'(LOS_RECOVER - 1);

   typedef enum logic [0:0] {
      ST_LOCKED = 1'b0,
      ST_LOS    = 1'b1
   } los_state_t;

   // input path
   logic       r_iob_clk;
   logic       r_iob_data;
   logic       r_meta_clk;
   logic       r_meta_data;
   logic       r_s_clk;
   logic       r_s_data;

   // glitch filter
   logic       r_f_clk;
   logic [2:0] r_fcnt;
   logic       w_diff;
   logic       w_accept;
   logic       w_edge_lvl;
   logic       w_event;

   // event / capture
   logic       r_event;
   logic       r_cap;

   // loss-of-signal monitor
   logic [5:0] r_timer;
   logic       w_tmo_reach;
   los_state_t r_state;
   logic [3:0] r_rcnt;

   // registered outputs
   logic       r_out_data;
   logic       r_out_valid;
   logic       r_los;
   logic       r_los_chg;

   // ------------------------------------------------------------------------
   // Pad registers, intended to be packed into the input IOB flops. They
   // carry no reset so the tools can place them in the I/O cells.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      r_iob_clk  <= pad_rx_clk;
      r_iob_data <= pad_rx_data;
   end

   // Two-stage synchroniser behind the IOB registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta_clk  <= 1'b0;
         r_meta_data <= 1'b0;
         r_s_clk     <= 1'b0;
         r_s_data    <= 1'b0;
      end else begin
         r_meta_clk  <= r_iob_clk;
         r_meta_data <= r_iob_data;
         r_s_clk     <= r_meta_clk;
         r_s_data    <= r_meta_data;
      end
   end

   // ------------------------------------------------------------------------
   // Glitch filter: the synced clock must differ from the filtered level for
   // FILT_LEN consecutive cycles before the filtered level follows it. Any
   // return to the filtered level restarts the count, so pulses shorter than
   // FILT_LEN never reach r_f_clk.
   // ------------------------------------------------------------------------
   assign w_diff   = (r_s_clk != r_f_clk);
   assign w_accept = w_diff && (r_fcnt == c_FILT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_f_clk <= 1'b0;
         r_fcnt  <= 3'd0;
      end else if (w_accept) begin
         r_f_clk <= r_s_clk;
         r_fcnt  <= 3'd0;
      end else if (w_diff) begin
         r_fcnt  <= r_fcnt + 3'd1;
      end else begin
         r_fcnt  <= 3'd0;
      end
   end

   // Level the filtered clock must move to for an active edge.
   generate
      if (RX_EDGE != 0) begin : g_edge_rise
         assign w_edge_lvl = 1'b1;
      end else begin : g_edge_fall
         assign w_edge_lvl = 1'b0;
      end
   endgenerate

   assign w_event = w_accept && (r_s_clk == w_edge_lvl);

   // The data bit is taken in the same cycle the filtered clock moves, which
   // lands 3+FILT_LEN clk after the pad edge, well inside the bit cell.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_event <= 1'b0;
         r_cap   <= 1'b0;
      end else begin
         r_event <= w_event;
         if (w_event) begin
            r_cap <= r_s_data;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Idle timer: cleared by every event, otherwise counts up and saturates.
   // w_tmo_reach marks the cycle in which it is about to hit LOS_TIMEOUT;
   // a simultaneous event takes priority and suppresses the timeout.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= 6'd0;
      end else if (r_event) begin
         r_timer <= 6'd0;
      end else if (r_timer != c_TMO_MAX) begin
         r_timer <= r_timer + 6'd1;
      end
   end

   assign w_tmo_reach = !r_event && (r_timer == c_TMO_LAST);

   // ------------------------------------------------------------------------
   // LOS state machine with registered outputs. Bits are only delivered
   // while locked; the event that completes recovery is still suppressed
   // because the state is sampled before it changes.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_LOS;
         r_rcnt      <= 4'd0;
         r_los       <= 1'b1;
         r_los_chg   <= 1'b0;
         r_out_data  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_los_chg   <= 1'b0;
         r_out_valid <= 1'b0;

         if (r_event && (r_state == ST_LOCKED)) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_cap;
         end

         case (r_state)
            ST_LOCKED: begin
               if (w_tmo_reach) begin
                  r_state   <= ST_LOS;
                  r_los     <= 1'b1;
                  r_los_chg <= 1'b1;
                  r_rcnt    <= 4'd0;
               end
            end
            ST_LOS: begin
               if (r_event) begin
                  if (r_rcnt == c_REC_LAST) begin
                     r_state   <= ST_LOCKED;
                     r_los     <= 1'b0;
                     r_los_chg <= 1'b1;
                     r_rcnt    <= 4'd0;
                  end else begin
                     r_rcnt <= r_rcnt + 4'd1;
                  end
               end else if (w_tmo_reach) begin
                  // edges were too far apart: restart the recovery count
                  r_rcnt <= 4'd0;
               end
            end
            default: begin
               r_state <= ST_LOS;
               r_los   <= 1'b1;
               r_rcnt  <= 4'd0;
            end
         endcase
      end
   end

   assign out_data       = r_out_data;
   assign out_valid      = r_out_valid;
   assign status_los     = r_los;
   assign status_los_chg = r_los_chg;

endmodule
`default_nettype wire

// File: tb/tb_e1_rx_liu.sv
`default_nettype none
// ============================================================================
// Module   : tb_e1_rx_liu
// Purpose  : Self-checking bench for e1_rx_liu. Two instances share the pad
//            clock: one samples falling edges, the other rising edges, each
//            with its own data pad that changes on the opposite edge. A
//            reference model works from the pad edges the bench generates
//            (accepted level changes, fixed pad-to-strobe latency, idle-gap
//            and recovery rules) and is compared every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_e1_rx_liu;

   localparam int FILT_LEN    = 2;
   localparam int LOS_TIMEOUT = 63;
   localparam int LOS_RECOVER = 4;
   localparam int LAT         = 6;     // pad edge to strobe, clk cycles
   localparam int MAXC        = 8192;

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic pad_rx_clk = 1'b0;
   logic pad_d0     = 1'b0;
   logic pad_d1     = 1'b0;
   logic od0, ov0, ol0, oc0;
   logic od1, ov1, ol1, oc1;

   always #5 clk = ~clk;

   e1_rx_liu #(
      .RX_EDGE(0), .FILT_LEN(FILT_LEN),
      .LOS_TIMEOUT(LOS_TIMEOUT), .LOS_RECOVER(LOS_RECOVER)
   ) u_dut_fall (
      .clk(clk), .rst_n(rst_n), .pad_rx_data(pad_d0), .pad_rx_clk(pad_rx_clk),
      .out_data(od0), .out_valid(ov0), .status_los(ol0), .status_los_chg(oc0)
   );

   e1_rx_liu #(
      .RX_EDGE(1), .FILT_LEN(FILT_LEN),
      .LOS_TIMEOUT(LOS_TIMEOUT), .LOS_RECOVER(LOS_RECOVER)
   ) u_dut_rise (
      .clk(clk), .rst_n(rst_n), .pad_rx_data(pad_d1), .pad_rx_clk(pad_rx_clk),
      .out_data(od1), .out_valid(ov1), .status_los(ol1), .status_los_chg(oc1)
   );

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // expected strobes, indexed by the cycle they must appear in
   logic ev_tab [2][MAXC];
   logic ev_dat [2][MAXC];

   logic m_los  [2];
   int   m_rcnt [2];
   int   m_last [2];
   logic rst_hold;
   logic acc;           // last clock level the filter is expected to accept
   logic nxt;           // next bit of the shared sequence
   logic seq_q [$];
   logic rx0_q [$];
   logic rx1_q [$];
   logic [15:0] pat = 16'hA5A5;

   int   n_strobe [2];
   int   n_chg    [2];
   int   last_v   [2];
   int   los_rise [2];
   logic prev_los [2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s @cyc %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_cycle();
      logic v [2];
      logic d [2];
      logic l [2];
      logic c [2];
      v[0] = ov0; d[0] = od0; l[0] = ol0; c[0] = oc0;
      v[1] = ov1; d[1] = od1; l[1] = ol1; c[1] = oc1;
      for (int k = 0; k < 2; k++) begin
         logic ev;
         logic exp_v;
         logic exp_chg;
         exp_v   = 1'b0;
         exp_chg = 1'b0;
         if (rst_hold) begin
            chk($sformatf("rst_data%0d", k), d[k], 1'b0);
         end else begin
            ev    = (cyc < MAXC) ? ev_tab[k][cyc] : 1'b0;
            exp_v = ev && !m_los[k];
            if (ev) begin
               m_last[k] = cyc;
               if (m_los[k]) begin
                  m_rcnt[k]++;
                  if (m_rcnt[k] == LOS_RECOVER) begin
                     m_los[k]  = 1'b0;
                     m_rcnt[k] = 0;
                     exp_chg   = 1'b1;
                  end
               end
            end else if (cyc - m_last[k] == LOS_TIMEOUT) begin
               if (!m_los[k]) begin
                  m_los[k] = 1'b1;
                  exp_chg  = 1'b1;
               end else begin
                  m_rcnt[k] = 0;
               end
            end
         end
         chk($sformatf("valid%0d", k), v[k], exp_v);
         chk($sformatf("los%0d", k),   l[k], m_los[k]);
         chk($sformatf("chg%0d", k),   c[k], exp_chg);
         if (exp_v)
            chk($sformatf("data%0d", k), d[k], ev_dat[k][cyc]);
         if (v[k] === 1'b1) begin
            n_strobe[k]++;
            last_v[k] = cyc;
            if (k == 0) rx0_q.push_back(d[k]);
            else        rx1_q.push_back(d[k]);
         end
         if (c[k] === 1'b1) n_chg[k]++;
         if (l[k] === 1'b1 && prev_los[k] === 1'b0) los_rise[k] = cyc;
         prev_los[k] = l[k];
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      check_cycle();
   endtask

   // Hold pad_rx_clk at 'level' for 'len' cycles, noting the expected strobe
   // if the filter will accept this level as a new one.
   task automatic seg(input logic level, input int len);
      pad_rx_clk = level;
      if (len >= FILT_LEN && level !== acc && cyc + LAT < MAXC) begin
         acc = level;
         if (level) begin
            ev_tab[1][cyc+LAT] = 1'b1;
            ev_dat[1][cyc+LAT] = pad_d1;
         end else begin
            ev_tab[0][cyc+LAT] = 1'b1;
            ev_dat[0][cyc+LAT] = pad_d0;
         end
      end
      repeat (len) step();
   endtask

   // One bit cell: both instances see the same bit sequence.
   task automatic bit_period(input int h, input int l);
      pad_d0 = nxt;
      seg(1'b1, h);
      nxt    = seq_q.pop_front();
      pad_d1 = nxt;
      seg(1'b0, l);
   endtask

   task automatic glitch_period(input int glen);
      pad_d0 = nxt;
      seg(1'b1, 8);
      nxt    = seq_q.pop_front();
      pad_d1 = nxt;
      seg(1'b0, 3);
      seg(1'b1, glen);
      seg(1'b0, 8);
   endtask

   task automatic stream(input int n);
      for (int j = 0; j < n; j++)
         bit_period($urandom_range(7, 8), $urandom_range(7, 8));
   endtask

   task automatic clr_counts();
      for (int k = 0; k < 2; k++) begin
         n_strobe[k] = 0;
         n_chg[k]    = 0;
         los_rise[k] = -1;
         last_v[k]   = -1;
      end
      rx0_q.delete();
      rx1_q.delete();
   endtask

   task automatic reset_pulse();
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid0", ov0, 1'b0);
      chk("async_data0",  od0, 1'b0);
      chk("async_los0",   ol0, 1'b1);
      chk("async_chg0",   oc0, 1'b0);
      chk("async_valid1", ov1, 1'b0);
      chk("async_los1",   ol1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         m_los[k]  = 1'b1;
         m_rcnt[k] = 0;
      end
      rst_hold = 1'b1;
      step();
      rst_n    = 1'b1;
      rst_hold = 1'b0;
      m_last[0] = cyc;
      m_last[1] = cyc;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < MAXC; j++) begin
            ev_tab[k][j] = 1'b0;
            ev_dat[k][j] = 1'b0;
         end
         m_los[k]    = 1'b1;
         m_rcnt[k]   = 0;
         prev_los[k] = 1'b1;
      end
      for (int j = 0; j < 16; j++) seq_q.push_back(pat[15-j]);
      for (int j = 0; j < 200; j++) seq_q.push_back(1'($urandom_range(0, 1)));
      acc    = 1'b0;
      nxt    = seq_q.pop_front();
      pad_d1 = nxt;
      clr_counts();

      // power-on reset
      rst_hold = 1'b1;
      repeat (4) step();
      rst_n    = 1'b1;
      rst_hold = 1'b0;
      m_last[0] = cyc;
      m_last[1] = cyc;

      // clean 2.048 MHz clock, A5A5 MSB first
      clr_counts();
      repeat (16) bit_period(8, 7);
      chk("s1_strobes0", n_strobe[0], 12);
      chk("s1_strobes1", n_strobe[1], 12);
      chk("s1_chg0", n_chg[0], 1);
      chk("s1_chg1", n_chg[1], 1);
      chk("s1_los0", ol0, 1'b0);
      for (int j = 0; j < 12; j++) begin
         chk($sformatf("s1_bit0_%0d", j), rx0_q[j], pat[11-j]);
         chk($sformatf("s1_bit1_%0d", j), rx1_q[j], pat[11-j]);
      end

      // single-cycle glitches are ignored
      clr_counts();
      repeat (3) glitch_period(1);
      chk("g1_strobes0", n_strobe[0], 3);
      chk("g1_strobes1", n_strobe[1], 3);

      // a two-cycle pulse is a real edge pair
      clr_counts();
      glitch_period(2);
      chk("g2_strobes0", n_strobe[0], 2);
      chk("g2_strobes1", n_strobe[1], 2);

      // clock stops while locked
      stream(4);
      clr_counts();
      bit_period(8, 77);
      chk("stop_strobes0", n_strobe[0], 1);
      chk("stop_chg0", n_chg[0], 1);
      chk("stop_chg1", n_chg[1], 1);
      chk("stop_los0", ol0, 1'b1);
      chk("stop_delay0", los_rise[0] - last_v[0], LOS_TIMEOUT);
      chk("stop_delay1", los_rise[1] - last_v[1], LOS_TIMEOUT);

      // recovery interrupted by a long gap
      clr_counts();
      bit_period(8, 7);
      bit_period(8, 7);
      bit_period(8, 64);
      repeat (3) bit_period(8, 7);
      chk("rec_still_los0", ol0, 1'b1);
      chk("rec_still_los1", ol1, 1'b1);
      bit_period(8, 7);
      chk("rec_los0", ol0, 1'b0);
      chk("rec_los1", ol1, 1'b0);
      chk("rec_chg0", n_chg[0], 1);
      chk("rec_strobes0", n_strobe[0], 0);
      chk("rec_strobes1", n_strobe[1], 0);

      // reset pulse during locked streaming
      stream(6);
      pad_d0 = nxt;
      seg(1'b1, 8);
      nxt    = seq_q.pop_front();
      pad_d1 = nxt;
      seg(1'b0, 8);
      reset_pulse();
      seg(1'b0, 5);
      clr_counts();
      stream(12);
      chk("rst_strobes0", n_strobe[0], 8);
      chk("rst_strobes1", n_strobe[1], 8);
      chk("rst_chg0", n_chg[0], 1);
      chk("rst_los1", ol1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
